fb_write_arbiter: RTL
=====================

Name: fb_write_arbiter

Overview:
- Shares the single frame-buffer write port (76800-pixel buffer, 17-bit address, 24-bit RGB data) between NUM_REQ drawing engines, e.g. map drawer, sprite drawer and text overlay.
- Each engine requests ownership, receives an exclusive grant, then streams writes until it releases.
- Ownership passes round-robin, with one dead cycle at every handover, so no two engines ever write in the same cycle.

Parameters:
- NUM_REQ, 3, number of requesting engines (2..8).
- MAX_HOLD, 1024, max consecutive owned cycles before preemption (only used with FB_ARB_PREEMPT_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_REQ  per-engine ownership request; held high for the whole burst.
- req_we  input  NUM_REQ  per-engine write strobe.
- req_addr  input  17*NUM_REQ  per-engine pixel address; engine i on bits [17i+16:17i].
- req_data  input  24*NUM_REQ  per-engine pixel data; engine i on bits [24i+23:24i].
- gnt  output  NUM_REQ  one-hot grant, registered.
- owner  output  3  index of current owner; valid only while busy=1.
- busy  output  1  high in OWN state.
- fb_we  output  1  frame-buffer write enable.
- fb_addr  output  17  frame-buffer address.
- fb_data  output  24  frame-buffer write data.

Behaviour:
- Reset values:
  - gnt=0, owner=0, busy=0, fb_we=0, fb_addr=0, fb_data=0.
  - state=IDLE, hold counter=0.
  - last_owner=NUM_REQ-1, so engine 0 wins the first arbitration.
- States are IDLE, OWN and SWITCH.
- IDLE:
  - If any req is high, select the first requester searching from last_owner+1 upward with wrap, then go to OWN.
  - gnt and owner register on the same edge. Latency: req high at edge n -> gnt high after edge n+1.
  - If no req is high, stay in IDLE.
- OWN:
  - gnt[owner]=1, busy=1.
  - fb_we = req_we[owner] & gnt[owner]; fb_addr and fb_data are combinational muxes of the owner's slice.
  - fb_we/addr/data are zero-latency from the owner's inputs.
  - req_we from non-owners is ignored; it has no effect and no error.
  - If req[owner]=0, go to SWITCH and set last_owner=owner.
  - A write presented in the same cycle req drops is still forwarded, because gnt is still high in that cycle.
- SWITCH:
  - Exactly one cycle with gnt=0, busy=0, fb_we=0.
  - Next state is OWN with a new round-robin pick if any req is high, else IDLE.
  - The departing engine may be re-picked only if no other engine is requesting.
- In OWN, fb_addr and fb_data follow the owner's slice. In IDLE and SWITCH, fb_addr and fb_data are 0.
- Simultaneous requests resolve strictly round-robin relative to last_owner. No fixed priority.
- The hold counter:
  - clears on entry to OWN;
  - increments each OWN cycle;
  - saturates at MAX_HOLD-1.
- Reset mid-burst: everything returns to reset values asynchronously. Engines must re-request.
- Address range (0..76799) is the engine's responsibility and is passed through unchecked.

Optional Feature:
- Macro name: FB_ARB_PREEMPT_EN.
- Defined:
  - In OWN, if the hold counter equals MAX_HOLD-1 and any other req is high, go to SWITCH even though req[owner]=1. last_owner=owner.
  - The preempted engine sees gnt drop and must stall its writes until re-granted. Writes it presents while gnt=0 are discarded.
  - If no other engine is requesting, the owner keeps the port and the counter stays saturated.
- Undefined:
  - The owner holds the port until it drops req; MAX_HOLD is unused.
  - The hold counter may be omitted.

Test Plan:
- Reset, then req=3'b001, engine 0 writes addr 0..3 with data 24'h0000FF -> gnt=001 one cycle after req; fb_we pulses with addr 0,1,2,3. After req drops: one SWITCH cycle with gnt=0, then IDLE.
- req=3'b111 from reset, each engine holding for 4 cycles -> grant order 0,1,2,0. Exactly one gnt=0 cycle between owners. fb_we is never high while gnt=0.
- Engine 1 owns the port; engine 2 drives req_we=1, addr 17'd500 -> fb_addr never equals 500 during engine 1's tenure, and fb_we matches only engine 1's strobes.
- Engine 0 writes pixel 17'd76799, data 24'hABCDEF -> fb_addr=76799 and fb_data=ABCDEF pass through unaltered.
- FB_ARB_PREEMPT_EN, MAX_HOLD=8: engine 0 holds req indefinitely, engine 1 requests at cycle 3 -> gnt[0] drops after 8 owned cycles, one SWITCH cycle, then gnt[1]=1. Repeat without the macro -> gnt[0] stays high and engine 1 is never granted.
- Assert rst mid-burst while engine 2 owns the port -> gnt, fb_we, busy are 0 immediately. After release with req=111 -> engine 0 is granted first.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the single frame-buffer write port shared by NUM_REQ drawing engines.
// Define FB_ARB_PREEMPT_EN to let a waiting engine preempt an owner after MAX_HOLD owned cycles.
module fb_write_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [17*NUM_REQ-1:0] req_addr,
  input  logic [24*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [2:0]            owner,
  output logic                  busy,
  output logic                  fb_we,
  output logic [16:0]           fb_addr,
  output logic [23:0]           fb_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_OWN    = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;

  localparam int unsigned        HOLD_W   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

`ifdef FB_ARB_PREEMPT_EN
  localparam bit PREEMPT_EN = 1'b1;
`else
  localparam bit PREEMPT_EN = 1'b0;
`endif

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               pick_hi_vld, pick_lo_vld, pick_vld;
  logic [2:0]         pick_hi, pick_lo, pick_idx;
  logic               own_req, own_we, own_gnt;
  logic [NUM_REQ-1:0] others;
  logic [16:0]        own_addr;
  logic [23:0]        own_data;
  logic               preempt;

  // Round-robin: first requester above last_q, otherwise wrap to the lowest requester.
  always_comb begin
    pick_hi_vld = 1'b0;
    pick_lo_vld = 1'b0;
    pick_hi     = '0;
    pick_lo     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !pick_lo_vld) begin
        pick_lo_vld = 1'b1;
        pick_lo     = 3'(i);
      end
      if (req[i] && !pick_hi_vld && (3'(i) > last_q)) begin
        pick_hi_vld = 1'b1;
        pick_hi     = 3'(i);
      end
    end
    pick_vld = pick_hi_vld | pick_lo_vld;
    pick_idx = pick_hi_vld ? pick_hi : pick_lo;
  end

  always_comb begin
    own_req  = 1'b0;
    own_we   = 1'b0;
    own_gnt  = 1'b0;
    own_addr = '0;
    own_data = '0;
    others   = req;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req   = req[i];
        own_we    = req_we[i];
        own_gnt   = gnt_q[i];
        own_addr  = req_addr[17*i +: 17];
        own_data  = req_data[24*i +: 24];
        others[i] = 1'b0;
      end
    end
  end

  assign preempt = PREEMPT_EN && (hold_q == HOLD_MAX) && (|others);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE, S_SWITCH: begin
        if (pick_vld) begin
          state_d = S_OWN;
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          hold_d  = '0;
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      S_OWN: begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
        if (!own_req || preempt) begin
          state_d = S_SWITCH;
          gnt_d   = '0;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= 3'(NUM_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == S_OWN);
  // Write path is combinational from the owner's slice so a burst has no extra latency.
  assign fb_we   = busy & own_we & own_gnt;
  assign fb_addr = busy ? own_addr : '0;
  assign fb_data = busy ? own_data : '0;

endmodule
